// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Constants and types shared by the exec and memory stages of the dual-slot
// pipeline.
//   OP_LOAD / OP_STORE : upper-slot opcodes (inst[63:58])
//   BUBBLE_INST        : the no-op bundle. It is the value inserted while a
//                        stage is stalled or reset.
//   mem_state_t        : memory-stage sequencing states
// ----------------------------------------------------------------------------
package core_pkg;

    localparam logic [5:0]  OP_LOAD     = 6'b010000;
    localparam logic [5:0]  OP_STORE    = 6'b010001;
    localparam logic [63:0] BUBBLE_INST = {3'b111, 29'b0, 3'b111, 29'b0};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_store_op(input logic [63:0] bundle);
        return bundle[63:58] == OP_STORE;
    endfunction

endpackage

// File: rtl/mem_hold_reg.sv
// ----------------------------------------------------------------------------
// mem_hold_reg
// Parks the parts of a load bundle that do not come from memory while the
// BRAM read is in flight. These parts are the bundle, the destination
// registers, the write-enables, and the lower-slot result. Holding them lets
// both slots reach writeback in the same cycle.
// Ports:
//   clk, rstn        clock, synchronous active-low reset (clears flags only)
//   load_en_i        capture enable (a load accepted this cycle)
//   inst_i           64-bit bundle
//   u_rt_i/_flag_i   upper destination register / write-enable
//   l_tdata_i        lower-slot result
//   l_rt_i/_flag_i   lower destination register / write-enable
//   *_o              held copies of the above
// ----------------------------------------------------------------------------
module mem_hold_reg
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_en_i,
    input  logic [63:0] inst_i,
    input  logic [4:0]  u_rt_i,
    input  logic        u_rt_flag_i,
    input  logic [31:0] l_tdata_i,
    input  logic [4:0]  l_rt_i,
    input  logic        l_rt_flag_i,
    output logic [63:0] inst_o,
    output logic [4:0]  u_rt_o,
    output logic        u_rt_flag_o,
    output logic [31:0] l_tdata_o,
    output logic [4:0]  l_rt_o,
    output logic        l_rt_flag_o
);

    logic [63:0] inst_q;
    logic [4:0]  u_rt_q;
    logic        u_rt_flag_q;
    logic [31:0] l_tdata_q;
    logic [4:0]  l_rt_q;
    logic        l_rt_flag_q;

    // Flags are cleared on reset so that a stale hold can never enable a
    // register write. The data fields are only meaningful when paired with a
    // flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            u_rt_flag_q <= 1'b0;
            l_rt_flag_q <= 1'b0;
        end else if (load_en_i) begin
            u_rt_flag_q <= u_rt_flag_i;
            l_rt_flag_q <= l_rt_flag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en_i) begin
            inst_q    <= inst_i;
            u_rt_q    <= u_rt_i;
            l_tdata_q <= l_tdata_i;
            l_rt_q    <= l_rt_i;
        end
    end

    assign inst_o      = inst_q;
    assign u_rt_o      = u_rt_q;
    assign u_rt_flag_o = u_rt_flag_q;
    assign l_tdata_o   = l_tdata_q;
    assign l_rt_o      = l_rt_q;
    assign l_rt_flag_o = l_rt_flag_q;

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory stage of the dual-slot pipeline. The upper slot [63:32] performs
// loads and stores against a synchronous BRAM with RD_LAT cycles of read
// latency. The lower slot [31:0] passes straight through.
//
// A load stalls exec (mem_stall) until the read data is available. The load
// then retires both slots to writeback together.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   ex_to_mem_ready            upper slot of inst is a load
//   inst                       bundle from exec
//   u_tdata / u_sdata          upper result (word address) / store data
//   u_rt / u_rt_flag           upper destination register / write-enable
//   l_tdata / l_rt / l_rt_flag lower result / destination / write-enable
//   mem_stall                  combinational hold request to exec
//   dmem_en/we/addr/din/dout   BRAM port
//   inst_to_wb, u_wdata, l_wdata, *_rt_to_wb, *_rt_flag_to_wb
//                              registered writeback bundle
// ----------------------------------------------------------------------------
module mem_stage
    import core_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_to_mem_ready,
    input  logic [63:0]       inst,
    input  logic [31:0]       u_tdata,
    input  logic [31:0]       u_sdata,
    input  logic [4:0]        u_rt,
    input  logic              u_rt_flag,
    input  logic [31:0]       l_tdata,
    input  logic [4:0]        l_rt,
    input  logic              l_rt_flag,
    output logic              mem_stall,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    input  logic [31:0]       dmem_dout,
    output logic [63:0]       inst_to_wb,
    output logic [31:0]       u_wdata,
    output logic [31:0]       l_wdata,
    output logic [4:0]        u_rt_to_wb,
    output logic [4:0]        l_rt_to_wb,
    output logic              u_rt_flag_to_wb,
    output logic              l_rt_flag_to_wb
);

    localparam int              CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      inst_wb_q, inst_wb_d;
    logic [31:0]      u_wdata_q, u_wdata_d;
    logic [31:0]      l_wdata_q, l_wdata_d;
    logic [4:0]       u_rt_q, u_rt_d;
    logic [4:0]       l_rt_q, l_rt_d;
    logic             u_flag_q, u_flag_d;
    logic             l_flag_q, l_flag_d;

    logic        is_idle, is_load, is_st, lat_done, hold_en;
    logic [63:0] h_inst;
    logic [4:0]  h_u_rt, h_l_rt;
    logic        h_u_flag, h_l_flag;
    logic [31:0] h_l_tdata;

    // The address bits of u_tdata above the BRAM depth are deliberately
    // ignored. The memory is word-addressed and has no wrap detection.
    logic unused_addr_hi;
    assign unused_addr_hi = ^u_tdata[31:ADDR_W];

    assign is_idle  = (state_q == IDLE);
    assign is_load  = ex_to_mem_ready;
    // The load flag takes priority if exec ever marks a store opcode as a load.
    assign is_st    = is_store_op(inst) & ~is_load;
    assign lat_done = (state_q == WAIT) && (cnt_q == LAT_C);
    assign hold_en  = is_idle & is_load;

    // The BRAM is only touched from IDLE. Inputs seen during WAIT are bubbles.
    assign dmem_en   = is_idle & (is_load | is_st);
    assign dmem_we   = is_idle & is_st;
    assign dmem_addr = u_tdata[ADDR_W-1:0];
    assign dmem_din  = u_sdata;

    // The stall is high on the cycle a load is accepted and on every WAIT
    // cycle except the last. Dropping it one cycle early lets exec present
    // the next bundle exactly when this stage returns to IDLE.
    assign mem_stall = is_idle ? is_load : ~lat_done;

    mem_hold_reg u_hold (
        .clk         (clk),
        .rstn        (rstn),
        .load_en_i   (hold_en),
        .inst_i      (inst),
        .u_rt_i      (u_rt),
        .u_rt_flag_i (u_rt_flag),
        .l_tdata_i   (l_tdata),
        .l_rt_i      (l_rt),
        .l_rt_flag_i (l_rt_flag),
        .inst_o      (h_inst),
        .u_rt_o      (h_u_rt),
        .u_rt_flag_o (h_u_flag),
        .l_tdata_o   (h_l_tdata),
        .l_rt_o      (h_l_rt),
        .l_rt_flag_o (h_l_flag)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_wb_d = BUBBLE_INST;
        u_wdata_d = u_wdata_q;
        l_wdata_d = l_wdata_q;
        u_rt_d    = u_rt_q;
        l_rt_d    = l_rt_q;
        u_flag_d  = 1'b0;
        l_flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load) begin
                    // Writeback sees a bubble until the read data returns.
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    inst_wb_d = inst;
                    u_wdata_d = u_tdata;
                    l_wdata_d = l_tdata;
                    u_rt_d    = u_rt;
                    l_rt_d    = l_rt;
                    // A store has no register result.
                    u_flag_d  = u_rt_flag & ~is_st;
                    l_flag_d  = l_rt_flag;
                end
            end
            WAIT: begin
                if (lat_done) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    inst_wb_d = h_inst;
                    u_wdata_d = dmem_dout;
                    l_wdata_d = h_l_tdata;
                    u_rt_d    = h_u_rt;
                    l_rt_d    = h_l_rt;
                    u_flag_d  = h_u_flag;
                    l_flag_d  = h_l_flag;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            inst_wb_q <= BUBBLE_INST;
            u_wdata_q <= '0;
            l_wdata_q <= '0;
            u_rt_q    <= '0;
            l_rt_q    <= '0;
            u_flag_q  <= 1'b0;
            l_flag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_wb_q <= inst_wb_d;
            u_wdata_q <= u_wdata_d;
            l_wdata_q <= l_wdata_d;
            u_rt_q    <= u_rt_d;
            l_rt_q    <= l_rt_d;
            u_flag_q  <= u_flag_d;
            l_flag_q  <= l_flag_d;
        end
    end

    assign inst_to_wb      = inst_wb_q;
    assign u_wdata         = u_wdata_q;
    assign l_wdata         = l_wdata_q;
    assign u_rt_to_wb      = u_rt_q;
    assign l_rt_to_wb      = l_rt_q;
    assign u_rt_flag_to_wb = u_flag_q;
    assign l_rt_flag_to_wb = l_flag_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import core_pkg::*;

    localparam int ADDR_W = 17;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rstn;
    logic ex_to_mem_ready;
    logic [63:0] inst;
    logic [31:0] u_tdata, u_sdata, l_tdata;
    logic [4:0]  u_rt, l_rt;
    logic        u_rt_flag, l_rt_flag;
    logic        mem_stall, dmem_en, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0] dmem_din, dmem_dout;
    logic [63:0] inst_to_wb;
    logic [31:0] u_wdata, l_wdata;
    logic [4:0]  u_rt_to_wb, l_rt_to_wb;
    logic        u_rt_flag_to_wb, l_rt_flag_to_wb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rstn(rstn), .ex_to_mem_ready(ex_to_mem_ready), .inst(inst),
        .u_tdata(u_tdata), .u_sdata(u_sdata), .u_rt(u_rt), .u_rt_flag(u_rt_flag),
        .l_tdata(l_tdata), .l_rt(l_rt), .l_rt_flag(l_rt_flag),
        .mem_stall(mem_stall), .dmem_en(dmem_en), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .inst_to_wb(inst_to_wb), .u_wdata(u_wdata), .l_wdata(l_wdata),
        .u_rt_to_wb(u_rt_to_wb), .l_rt_to_wb(l_rt_to_wb),
        .u_rt_flag_to_wb(u_rt_flag_to_wb), .l_rt_flag_to_wb(l_rt_flag_to_wb)
    );

    // Synchronous BRAM with RD_LAT cycles of read latency.
    logic [31:0] bram [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (dmem_en) begin
            if (dmem_we) bram[dmem_addr] <= dmem_din;
            rd_pipe[0] <= bram[dmem_addr];
        end
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign dmem_dout = rd_pipe[RD_LAT-1];

    // Reference memory contents: word address -> last stored value.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic drive(input logic ld, input logic [63:0] in, input logic [31:0] ut,
                         input logic [31:0] us, input logic [4:0] ur, input logic uf,
                         input logic [31:0] lt, input logic [4:0] lr, input logic lf);
        ex_to_mem_ready = ld; inst = in; u_tdata = ut; u_sdata = us;
        u_rt = ur; u_rt_flag = uf; l_tdata = lt; l_rt = lr; l_rt_flag = lf;
    endtask

    task automatic drive_bubble();
        drive(1'b0, BUBBLE_INST, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive_bubble();
        repeat (3) @(negedge clk);
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mem_stall); end
        total++; if ({u_rt_flag_to_wb, l_rt_flag_to_wb} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b want=00", u_rt_flag_to_wb, l_rt_flag_to_wb); end
        total++; if (inst_to_wb !== BUBBLE_INST) begin bad++; $display("FAIL reset_inst got=%h want=%h", inst_to_wb, BUBBLE_INST); end
        total++; if ({u_wdata, l_wdata} !== 64'h0) begin bad++; $display("FAIL reset_wdata got=%h/%h want=0/0", u_wdata, l_wdata); end
        rstn = 1'b1;
    endtask

    task automatic test_alu();
        logic [63:0] in;
        in = {6'd0, 58'h0ABC_DEF0_1234};
        drive(1'b0, in, 32'd5, 32'd0, 5'd1, 1'b1, 32'd7, 5'd2, 1'b1);
        #1;
        total++; if (mem_stall !== 1'b0 || dmem_en !== 1'b0) begin bad++; $display("FAIL alu_comb got stall=%b en=%b want 0 0", mem_stall, dmem_en); end
        @(negedge clk);
        total++; if (u_wdata !== 32'd5 || l_wdata !== 32'd7) begin bad++; $display("FAIL alu_data got=%0d/%0d want=5/7", u_wdata, l_wdata); end
        total++; if ({u_rt_flag_to_wb, l_rt_flag_to_wb} !== 2'b11 || inst_to_wb !== in) begin bad++; $display("FAIL alu_ctl got flags=%b%b inst=%h want 11 %h", u_rt_flag_to_wb, l_rt_flag_to_wb, inst_to_wb, in); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", mem_stall); end
        drive_bubble();
        @(negedge clk);
    endtask

    // Issues a load, follows it through its stall window and checks the
    // retirement against the reference memory. Returns at the negedge
    // where the result is visible, with bubble inputs still applied.
    task automatic test_load_seq(input string nm, input logic [31:0] ut, input logic [4:0] ur,
                                 input logic uf, input logic [31:0] lt, input logic [4:0] lr,
                                 input logic lf);
        logic [63:0] in;
        logic [31:0] exp_u;
        in = {OP_LOAD, 26'h0, $urandom};
        exp_u = ref_read(int'(ut[ADDR_W-1:0]));
        drive(1'b1, in, ut, $urandom, ur, uf, lt, lr, lf);
        #1;
        total++; if (mem_stall !== 1'b1 || dmem_en !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== ut[ADDR_W-1:0]) begin
            bad++; $display("FAIL %s_issue got stall=%b en=%b we=%b addr=%h want 1 1 0 %h", nm, mem_stall, dmem_en, dmem_we, dmem_addr, ut[ADDR_W-1:0]);
        end
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            drive_bubble();
            #1;
            total++; if (mem_stall !== (k < RD_LAT) || dmem_en !== 1'b0 || u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b0 || inst_to_wb !== BUBBLE_INST) begin
                bad++; $display("FAIL %s_wait%0d got stall=%b en=%b flags=%b%b inst=%h", nm, k, mem_stall, dmem_en, u_rt_flag_to_wb, l_rt_flag_to_wb, inst_to_wb);
            end
        end
        @(negedge clk);
        total++; if (u_wdata !== exp_u || u_rt_to_wb !== ur || u_rt_flag_to_wb !== uf) begin
            bad++; $display("FAIL %s_upper got data=%h rt=%0d f=%b want %h %0d %b", nm, u_wdata, u_rt_to_wb, u_rt_flag_to_wb, exp_u, ur, uf);
        end
        total++; if (l_wdata !== lt || l_rt_to_wb !== lr || l_rt_flag_to_wb !== lf || inst_to_wb !== in) begin
            bad++; $display("FAIL %s_lower got data=%h rt=%0d f=%b inst=%h want %h %0d %b %h", nm, l_wdata, l_rt_to_wb, l_rt_flag_to_wb, inst_to_wb, lt, lr, lf, in);
        end
    endtask

    task automatic test_store(input logic [31:0] ut, input logic [31:0] data);
        drive(1'b0, {OP_STORE, 58'h0}, ut, data, 5'd9, 1'b1, 32'h55, 5'd6, 1'b1);
        #1;
        total++; if (dmem_en !== 1'b1 || dmem_we !== 1'b1 || mem_stall !== 1'b0 || dmem_din !== data || dmem_addr !== ut[ADDR_W-1:0]) begin
            bad++; $display("FAIL store_comb got en=%b we=%b stall=%b din=%h addr=%h want 1 1 0 %h %h", dmem_en, dmem_we, mem_stall, dmem_din, dmem_addr, data, ut[ADDR_W-1:0]);
        end
        ref_mem[int'(ut[ADDR_W-1:0])] = data;
        @(negedge clk);
        total++; if (u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b1 || l_wdata !== 32'h55) begin
            bad++; $display("FAIL store_wb got uf=%b lf=%b l=%h want 0 1 00000055", u_rt_flag_to_wb, l_rt_flag_to_wb, l_wdata);
        end
        drive_bubble();
        #1;
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL store_we_once got=%b want=0", dmem_we); end
    endtask

    task automatic test_store_load();
        test_store(32'h10, 32'hDEADBEEF);
        test_load_seq("st_ld", 32'h10, 5'd3, 1'b1, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_load_lower();
        test_load_seq("ld_lower", 32'h10, 5'd7, 1'b1, 32'd9, 5'd4, 1'b1);
        test_load_seq("ld_noflag", 32'h10, 5'd8, 1'b0, 32'd1, 5'd2, 1'b1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        test_store(32'h1, 32'h11);
        @(negedge clk);
        test_store(32'h2, 32'h22);
        @(negedge clk);
        // Second load presented at the same negedge the first retires.
        test_load_seq("b2b_1", 32'h1, 5'd10, 1'b1, 32'hA, 5'd11, 1'b1);
        test_load_seq("b2b_2", 32'h2, 5'd12, 1'b1, 32'hB, 5'd13, 1'b1);
        total++; if (u_wdata !== 32'h22) begin bad++; $display("FAIL b2b_last got=%h want=00000022", u_wdata); end
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, {OP_LOAD, 58'h0}, 32'h2, 32'h0, 5'd5, 1'b1, 32'h3, 5'd6, 1'b1);
        @(negedge clk);
        drive_bubble();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        total++; if (mem_stall !== 1'b0 || u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b0 || inst_to_wb !== BUBBLE_INST) begin
            bad++; $display("FAIL midrst got stall=%b flags=%b%b inst=%h want 0 00 bubble", mem_stall, u_rt_flag_to_wb, l_rt_flag_to_wb, inst_to_wb);
        end
        @(negedge clk);
        total++; if (u_rt_flag_to_wb !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL midrst_after got uf=%b stall=%b want 0 0", u_rt_flag_to_wb, mem_stall); end
        test_load_seq("post_rst", 32'h1, 5'd14, 1'b1, 32'hC, 5'd15, 1'b1);
    endtask

    task automatic test_bubble();
        drive_bubble();
        #1;
        total++; if (dmem_en !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL bubble_comb got en=%b stall=%b want 0 0", dmem_en, mem_stall); end
        @(negedge clk);
        total++; if (inst_to_wb !== BUBBLE_INST || u_rt_flag_to_wb !== 1'b0 || l_rt_flag_to_wb !== 1'b0) begin
            bad++; $display("FAIL bubble_wb got inst=%h flags=%b%b", inst_to_wb, u_rt_flag_to_wb, l_rt_flag_to_wb);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [31:0] ut, lt;
            logic [4:0]  ur, lr;
            logic        uf, lf;
            logic [63:0] in;
            kind = int'($urandom_range(0, 2));
            // Small address range so loads revisit stored words; high bits random.
            ut = {$urandom_range(0, 32767), 13'h0, 4'($urandom_range(0, 15))};
            lt = $urandom; ur = 5'($urandom); lr = 5'($urandom);
            uf = 1'($urandom); lf = 1'($urandom);
            if (kind == 2) begin
                test_load_seq("rnd_ld", ut, ur, uf, lt, lr, lf);
            end else if (kind == 1) begin
                test_store(ut, $urandom);
            end else begin
                in = {$urandom, $urandom};
                if (in[63:58] == OP_STORE) in[58] = 1'b0;
                drive(1'b0, in, ut, $urandom, ur, uf, lt, lr, lf);
                #1;
                total++; if (dmem_en !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL rnd_alu_comb got en=%b stall=%b", dmem_en, mem_stall); end
                @(negedge clk);
                total++; if (u_wdata !== ut || l_wdata !== lt || u_rt_to_wb !== ur || l_rt_to_wb !== lr ||
                             u_rt_flag_to_wb !== uf || l_rt_flag_to_wb !== lf || inst_to_wb !== in) begin
                    bad++; $display("FAIL rnd_alu got u=%h l=%h rt=%0d/%0d f=%b%b want %h %h %0d/%0d %b%b", u_wdata, l_wdata, u_rt_to_wb, l_rt_to_wb, u_rt_flag_to_wb, l_rt_flag_to_wb, ut, lt, ur, lr, uf, lf);
                end
                drive_bubble();
            end
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) bram[a] = 32'h0;
        for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = 32'h0;
        rstn = 1'b0;
        drive_bubble();
        @(negedge clk);
        test_reset();
        test_alu();
        test_store_load();
        test_load_lower();
        test_back_to_back();
        test_reset_mid_load();
        test_bubble();
        test_random();
        test_bubble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
